// File: rtl/hartslag_pkg.sv
// Shared types and constants for the synthetic heartbeat generator.
// The optional gap jitter (HARTSLAG_JITTER_EN) uses the LFSR constants below.
package hartslag_pkg;

    localparam int unsigned SLAGEN_W = 8;
    localparam int unsigned EMIT_W   = SLAGEN_W + 1;
    localparam int unsigned LFSR_W   = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a bit mask over the state
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        KLAAR = 2'd2
    } deler_state_e;

    typedef enum logic {
        WACHT = 1'b0,
        HOOG  = 1'b1
    } puls_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/hartslag_generator_if.sv
// Control and output bundle of the heartbeat generator.
interface hartslag_generator_if;

    logic                                 enable;
    logic [hartslag_pkg::SLAGEN_W-1:0]    slagen_in;
    logic                                 pulse;
    logic                                 venster;
    logic [hartslag_pkg::SLAGEN_W-1:0]    actief_slagen;
    logic                                 busy;

    modport master (
        output enable, slagen_in,
        input  pulse, venster, actief_slagen, busy
    );

    modport slave (
        input  enable, slagen_in,
        output pulse, venster, actief_slagen, busy
    );

endinterface

// File: rtl/hartslag_deler.sv
// Sequential restoring divider: one quotient bit per cycle, CNT_W cycles in DIV.
// done_o is high during the single KLAAR cycle, when quotient_o is final.
module hartslag_deler
    import hartslag_pkg::*;
#(
    parameter int unsigned CNT_W = 28
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    dividend_i,
    input  logic [SLAGEN_W-1:0] divisor_i,
    output logic                done_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    quotient_o
);

    localparam int unsigned STEP_W = $clog2(CNT_W + 1);

    deler_state_e        state_q;
    logic [CNT_W-1:0]    aq_q;
    logic [SLAGEN_W-1:0] rem_q;
    logic [SLAGEN_W-1:0] dvs_q;
    logic [SLAGEN_W-1:0] rem_d;
    logic [STEP_W-1:0]   step_q;
    logic                busy_q;
    logic                done_q;
    logic [SLAGEN_W:0]   trial_c;
    logic                fits_c;

    // Remainder stays below the divisor, so the shifted trial fits in SLAGEN_W+1 bits
    always_comb begin
        trial_c = {rem_q, aq_q[CNT_W-1]};
        fits_c  = (trial_c >= {1'b0, dvs_q});
        rem_d   = fits_c ? SLAGEN_W'(trial_c - {1'b0, dvs_q}) : trial_c[SLAGEN_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            aq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        rem_q  <= '0;
                        dvs_q  <= divisor_i;
                        step_q <= '0;
                        if (divisor_i == '0) begin
                            aq_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= KLAAR;
                        end else begin
                            aq_q    <= dividend_i;
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q  <= rem_d;
                    aq_q   <= {aq_q[CNT_W-2:0], fits_c};
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(CNT_W - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= KLAAR;
                    end
                end
                KLAAR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign quotient_o = aq_q;

endmodule

// File: rtl/hartslag_generator.sv
// Synthetic heartbeat source: window counter, request latches and pulse FSM.
// Define HARTSLAG_JITTER_EN to shorten each beat gap by a pseudo-random amount.
module hartslag_generator
    import hartslag_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned PULSE_CYCLES  = 5000,
    parameter int unsigned CNT_W         = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    hartslag_generator_if.slave  bus
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(WINDOW_CYCLES);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    ph_q, ph_d;
    logic [CNT_W-1:0]    ival_q, quot_hold_q;
    logic [CNT_W-1:0]    gap_c, wp_c, half_c;
    logic [EMIT_W-1:0]   emitted_q;
    logic [SLAGEN_W-1:0] pending_q, actief_q;
    logic                venster_q, pulse_q, start_q;
    logic                win_start_c, term_c;
    puls_state_e         pstate_q;

    logic                deler_done;
    logic                deler_busy;
    logic [CNT_W-1:0]    deler_quot;

    // cnt_q is the window offset of the cycle entered at the next edge
    always_comb begin
        win_start_c = bus.enable && (cnt_q == '0);
        cnt_d       = '0;
        if (bus.enable) begin
            cnt_d = (cnt_q == WIN_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        half_c = ival_q >> 1;
        wp_c   = (32'(half_c) < PULSE_CYCLES) ? half_c : CNT_W'(PULSE_CYCLES);
        if (wp_c == '0) begin
            wp_c = CNT_W'(1);
        end

        ph_d = '0;
        if (bus.enable && !win_start_c && ((ph_q + CNT_W'(1)) != gap_c)) begin
            ph_d = ph_q + CNT_W'(1);
        end

        term_c = bus.enable && !win_start_c && (pstate_q == HOOG) && (ph_q == wp_c);
    end

`ifdef HARTSLAG_JITTER_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic [31:0]       jit_c;

    always_comb begin
        jit_c = 32'(lfsr_q) & 32'(ival_q >> 4);
        gap_c = ival_q - CNT_W'(jit_c);
    end

    // Advances once per completed pulse; never reseeded outside reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (term_c) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end
`else
    assign gap_c = ival_q;
`endif

    // Window counter and per-window latches: request now, emission next window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            venster_q   <= 1'b0;
            start_q     <= 1'b0;
            pending_q   <= '0;
            actief_q    <= '0;
            ival_q      <= '0;
            quot_hold_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            venster_q <= win_start_c;
            start_q   <= win_start_c;
            if (deler_done) begin
                quot_hold_q <= deler_quot;
            end
            if (win_start_c) begin
                pending_q <= bus.slagen_in;
                actief_q  <= pending_q;
                ival_q    <= quot_hold_q;
            end
        end
    end

    // Pulse FSM: a window start always forces WACHT, so termination wins there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pstate_q  <= WACHT;
            pulse_q   <= 1'b0;
            emitted_q <= '0;
            ph_q      <= '0;
        end else begin
            ph_q <= ph_d;
            if (!bus.enable || win_start_c) begin
                pstate_q  <= WACHT;
                pulse_q   <= 1'b0;
                emitted_q <= '0;
            end else begin
                case (pstate_q)
                    WACHT: begin
                        if ((ph_d == CNT_W'(1)) && (emitted_q < {1'b0, actief_q})) begin
                            pstate_q <= HOOG;
                            pulse_q  <= 1'b1;
                        end
                    end
                    HOOG: begin
                        if (term_c) begin
                            pstate_q  <= WACHT;
                            pulse_q   <= 1'b0;
                            emitted_q <= emitted_q + EMIT_W'(1);
                        end
                    end
                    default: pstate_q <= WACHT;
                endcase
            end
        end
    end

    hartslag_deler #(
        .CNT_W (CNT_W)
    ) u_deler (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (!bus.enable),
        .start_i    (start_q),
        .dividend_i (DIVIDEND),
        .divisor_i  (pending_q),
        .done_o     (deler_done),
        .busy_o     (deler_busy),
        .quotient_o (deler_quot)
    );

    assign bus.pulse         = pulse_q;
    assign bus.venster       = venster_q;
    assign bus.actief_slagen = actief_q;
    assign bus.busy          = deler_busy;

endmodule

// File: tb/tb_hartslag_generator.sv
// Directed bench for hartslag_generator at WINDOW_CYCLES=1000, PULSE_CYCLES=10, CNT_W=10.
module tb_hartslag_generator;

    localparam int unsigned W  = 1000;
    localparam int unsigned P  = 10;
    localparam int unsigned CW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hartslag_generator_if bus ();

    hartslag_generator #(
        .WINDOW_CYCLES (W),
        .PULSE_CYCLES  (P),
        .CNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int rise [0:255];
    int wid  [0:255];
    int npulse, busy_cnt, busy_first, vext, act_seen, v_next;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then enable so that the next sampled cycle is window 0, offset 0
    task automatic restart(input int s);
        bus.enable    = 1'b0;
        bus.slagen_in = 8'(s);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.enable = 1'b1;
        step();
    endtask

    // Observe one full window starting at its offset-0 cycle
    task automatic measure(input int chg_off, input int chg_val);
        int prev;
        prev = 0; npulse = 0; busy_cnt = 0; busy_first = -1; vext = 0;
        for (int k = 0; k < 256; k++) wid[k] = 0;
        act_seen = int'(bus.actief_slagen);
        for (int o = 0; o < int'(W); o++) begin
            if (o == chg_off) bus.slagen_in = 8'(chg_val);
            if (o > 0 && bus.venster) vext++;
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = o;
            end
            if (bus.pulse && prev == 0) begin
                if (npulse < 256) rise[npulse] = o;
                npulse++;
            end
            if (bus.pulse && npulse > 0 && npulse <= 256) wid[npulse-1]++;
            prev = int'(bus.pulse);
            step();
        end
        v_next = int'(bus.venster);
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.slagen_in = 8'd4; reset = 1'b1;
        step();
        n_cmp++; if (bus.pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse got %b want 0", bus.pulse); end
        n_cmp++; if (bus.venster !== 1'b0) begin n_err++; $display("FAIL rst_venster got %b want 0", bus.venster); end
        n_cmp++; if (bus.actief_slagen !== 8'd0) begin n_err++; $display("FAIL rst_actief got %0d want 0", bus.actief_slagen); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        reset = 1'b0; bus.enable = 1'b1;
        step();
        n_cmp++; if (bus.venster !== 1'b1) begin n_err++; $display("FAIL rst_first_venster got %b want 1", bus.venster); end
        step();
        n_cmp++; if (bus.venster !== 1'b0) begin n_err++; $display("FAIL rst_second_venster got %b want 0", bus.venster); end
    endtask

    task automatic test_four_beats();
        restart(4);
        measure(-1, 0);
        n_cmp++; if (npulse != 0) begin n_err++; $display("FAIL four_w0_pulses got %0d want 0", npulse); end
        n_cmp++; if (busy_cnt != 11) begin n_err++; $display("FAIL four_w0_busy_len got %0d want 11", busy_cnt); end
        n_cmp++; if (busy_first != 1) begin n_err++; $display("FAIL four_w0_busy_first got %0d want 1", busy_first); end
        n_cmp++; if (v_next != 1) begin n_err++; $display("FAIL four_w0_period got %0d want 1", v_next); end
        measure(-1, 0);
        n_cmp++; if (npulse != 4) begin n_err++; $display("FAIL four_w1_pulses got %0d want 4", npulse); end
        n_cmp++; if (act_seen != 4) begin n_err++; $display("FAIL four_w1_actief got %0d want 4", act_seen); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rise[k] != 1 + 250*k) begin n_err++; $display("FAIL four_rise%0d got %0d want %0d", k, rise[k], 1 + 250*k); end
            n_cmp++; if (wid[k] != 10) begin n_err++; $display("FAIL four_width%0d got %0d want 10", k, wid[k]); end
        end
        n_cmp++; if (vext != 0) begin n_err++; $display("FAIL four_w1_extra_venster got %0d want 0", vext); end
        n_cmp++; if (v_next != 1) begin n_err++; $display("FAIL four_w1_period got %0d want 1", v_next); end
    endtask

    // Entered at window 2 offset 0 of the four-beat run
    task automatic test_reset_midrun();
        step(); step(); step();
        n_cmp++; if (bus.pulse !== 1'b1) begin n_err++; $display("FAIL mid_pre_pulse got %b want 1", bus.pulse); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got %b want 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.pulse !== 1'b0) begin n_err++; $display("FAIL mid_pulse got %b want 0", bus.pulse); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.actief_slagen !== 8'd0) begin n_err++; $display("FAIL mid_actief got %0d want 0", bus.actief_slagen); end
        n_cmp++; if (bus.venster !== 1'b0) begin n_err++; $display("FAIL mid_venster got %b want 0", bus.venster); end
        step();
        reset = 1'b0; bus.enable = 1'b1;
        step();
        n_cmp++; if (bus.venster !== 1'b1) begin n_err++; $display("FAIL mid_restart_venster got %b want 1", bus.venster); end
    endtask

    task automatic test_zero();
        restart(0);
        for (int w = 0; w < 2; w++) begin
            measure(-1, 0);
            n_cmp++; if (npulse != 0) begin n_err++; $display("FAIL zero_w%0d_pulses got %0d want 0", w, npulse); end
            n_cmp++; if (busy_cnt != 1) begin n_err++; $display("FAIL zero_w%0d_busy_len got %0d want 1", w, busy_cnt); end
            n_cmp++; if (busy_first != 1) begin n_err++; $display("FAIL zero_w%0d_busy_first got %0d want 1", w, busy_first); end
            n_cmp++; if (v_next != 1 || vext != 0) begin n_err++; $display("FAIL zero_w%0d_venster got next=%0d extra=%0d want 1/0", w, v_next, vext); end
        end
    endtask

    task automatic test_max();
        int bad_rise, bad_wid;
        restart(255);
        measure(-1, 0);
        measure(-1, 0);
        bad_rise = 0; bad_wid = 0;
        for (int k = 0; k < 255; k++) begin
            if (rise[k] != 1 + 3*k) bad_rise++;
            if (wid[k] != 1) bad_wid++;
        end
        n_cmp++; if (npulse != 255) begin n_err++; $display("FAIL max_count got %0d want 255", npulse); end
        n_cmp++; if (act_seen != 255) begin n_err++; $display("FAIL max_actief got %0d want 255", act_seen); end
        n_cmp++; if (bad_rise != 0) begin n_err++; $display("FAIL max_offsets got %0d wrong want 0", bad_rise); end
        n_cmp++; if (bad_wid != 0) begin n_err++; $display("FAIL max_widths got %0d wrong want 0", bad_wid); end
        n_cmp++; if (rise[254] != 763) begin n_err++; $display("FAIL max_last_rise got %0d want 763", rise[254]); end
        n_cmp++; if (busy_cnt != 11) begin n_err++; $display("FAIL max_busy_len got %0d want 11", busy_cnt); end
    endtask

    task automatic test_change();
        restart(4);
        measure(-1, 0);
        measure(500, 2);
        n_cmp++; if (npulse != 4) begin n_err++; $display("FAIL chg_w1_pulses got %0d want 4", npulse); end
        measure(-1, 0);
        n_cmp++; if (npulse != 4) begin n_err++; $display("FAIL chg_w2_pulses got %0d want 4", npulse); end
        n_cmp++; if (act_seen != 4) begin n_err++; $display("FAIL chg_w2_actief got %0d want 4", act_seen); end
        measure(-1, 0);
        n_cmp++; if (npulse != 2) begin n_err++; $display("FAIL chg_w3_pulses got %0d want 2", npulse); end
        n_cmp++; if (act_seen != 2) begin n_err++; $display("FAIL chg_w3_actief got %0d want 2", act_seen); end
        n_cmp++; if (rise[1] != 501) begin n_err++; $display("FAIL chg_w3_rise1 got %0d want 501", rise[1]); end
    endtask

    // Entered at window 4 offset 0 of the change run
    task automatic test_enable();
        int act;
        step(); step();
        bus.enable = 1'b0;
        step();
        n_cmp++; if (bus.pulse !== 1'b0) begin n_err++; $display("FAIL en_pulse got %b want 0", bus.pulse); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL en_busy got %b want 0", bus.busy); end
        act = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.venster || bus.pulse || bus.busy) act++;
            step();
        end
        n_cmp++; if (act != 0) begin n_err++; $display("FAIL en_idle_activity got %0d want 0", act); end
        bus.enable = 1'b1;
        step();
        n_cmp++; if (bus.venster !== 1'b1) begin n_err++; $display("FAIL en_first_venster got %b want 1", bus.venster); end
        step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL en_busy_restart got %b want 1", bus.busy); end
    endtask

`ifdef HARTSLAG_JITTER_EN
    task automatic test_jitter();
        int g1 [0:6];
        int g;
        restart(8);
        measure(-1, 0);
        measure(-1, 0);
        n_cmp++; if (npulse != 8) begin n_err++; $display("FAIL jit_w1_pulses got %0d want 8", npulse); end
        for (int k = 0; k < 7; k++) begin
            g1[k] = rise[k+1] - rise[k];
            n_cmp++; if (g1[k] < 117 || g1[k] > 125) begin n_err++; $display("FAIL jit_gap%0d got %0d want 117..125", k, g1[k]); end
        end
        measure(-1, 0);
        n_cmp++; if (npulse != 8) begin n_err++; $display("FAIL jit_w2_pulses got %0d want 8", npulse); end
        restart(8);
        measure(-1, 0);
        measure(-1, 0);
        for (int k = 0; k < 7; k++) begin
            g = rise[k+1] - rise[k];
            n_cmp++; if (g != g1[k]) begin n_err++; $display("FAIL jit_repeat%0d got %0d want %0d", k, g, g1[k]); end
        end
    endtask
`endif

    initial begin
        bus.enable    = 1'b0;
        bus.slagen_in = 8'd0;
        test_reset();
        test_four_beats();
        test_reset_midrun();
        test_zero();
        test_max();
        test_change();
        test_enable();
`ifdef HARTSLAG_JITTER_EN
        test_jitter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hartslag_generator.md
# hartslag_generator

Synthetic heartbeat source: emits a pulse train carrying a programmable number of beats per measurement window, plus the matching window strobe. It drives the heart-rate counter's pulse input and its window clock, so the input path can be exercised in simulation and on the board without a sensor. Beat spacing comes from a sequential divider that runs once per window.

## Interface
- `WINDOW_CYCLES`, default 50_000_000: window length in `clk` cycles. Must be ≥ 512 and ≥ `CNT_W`+4.
- `PULSE_CYCLES`, default 5000: nominal pulse high time in cycles.
- `CNT_W`, default 28: counter and divider width. Must satisfy 2^`CNT_W` > `WINDOW_CYCLES`.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run when high. When low, the block is held idle.
- `slagen_in` in 8: requested beats per window.
- `pulse` out 1: heartbeat pulse. Connects to the counter's pulse input.
- `venster` out 1: one-cycle window strobe. Connects to the counter's window clock.
- `actief_slagen` out 8: beat count used in the current window.
- `busy` out 1: high while the divider runs.

## Operation
- **Reset.** All outputs reset to 0. Internal state also resets to 0: window counter, phase counter, emitted count, interval register, pending count. Reset asserted mid-pulse drops `pulse` immediately.
- **Window counter.** Counts 0..`WINDOW_CYCLES`-1 and wraps. `venster`=1 exactly in the cycle where the counter is 0.
- **`enable` low.** Counter held at 0, `venster`=0, `pulse`=0, divider stays in IDLE. `venster` fires in the first cycle with `enable`=1.
- **Latch at each `venster`.**
  - `slagen_in` → pending count, and the divider starts.
  - The previous pending count and its computed interval → `actief_slagen` and `I`.
  - Result: a request sampled at window N's strobe is emitted during window N+1.
- **Divider FSM** (`IDLE` → `DIV` → `KLAAR` → `IDLE`).
  - Restoring division `WINDOW_CYCLES` / pending, 1 quotient bit per cycle, `CNT_W` cycles in `DIV`.
  - `KLAAR` lasts 1 cycle and writes the quotient to a holding register.
  - Divisor 0 skips `DIV` and yields quotient 0.
- **Pulse FSM** (`WACHT` ↔ `HOOG`).
  - Pulse width `Wp` = max(1, min(`PULSE_CYCLES`, `I`>>1)).
  - Pulse k (k=0..`actief_slagen`-1) starts at window offset k·`I`.
  - After `actief_slagen` pulses, stay in `WACHT` until the next `venster`.
  - If `actief_slagen`=0, no pulses.
- **Count guarantee.** Since `I`=floor(W/b), b·`I` ≤ W, so exactly `actief_slagen` pulses fit in the window. Every pulse ends before the next window starts.
- **Width rules.** The offset comparison uses a `CNT_W`-bit phase counter. The emitted-pulse count is 9 bits, so the compare against 255 is safe.

## Timing
- `pulse` is registered. It is high during offsets k·`I`+1 through k·`I`+`Wp`, counting the `venster` cycle as offset 0.
- `busy` is high from offset 1 through offset `CNT_W`+1. It is low in all other cycles.
- Latency from request to effect: between 1 and 2 windows.
- If a window boundary coincides with pulse termination, termination wins. The new window's pulse 0 still rises at offset 1.

## Configuration
- Macro `HARTSLAG_JITTER_EN`.
- **Defined.**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances once per emitted pulse.
  - Each inter-pulse gap becomes `I` − (lfsr & (`I`>>4)).
  - Gaps only shorten, so the pulse count per window is unchanged.
- **Undefined.** Spacing is exactly `I`; no LFSR logic is present.

## Structure
- **Package `hartslag_pkg`:** divider and pulse state enums, LFSR seed and tap constants, `SLAGEN_W`=8.
- **Sub-module `hartslag_deler`:** sequential restoring divider.
  - Ports: start/done handshake, dividend, divisor, quotient.
  - `start` is accepted only in `IDLE`.
  - `done` is high for one cycle.
- The top level holds the window counter, pulse FSM and latch registers.

## Test plan
Unless stated, parameters are `WINDOW_CYCLES`=1000, `PULSE_CYCLES`=10, `CNT_W`=10, with `HARTSLAG_JITTER_EN` undefined.

1. Assert `reset` mid-run → all outputs 0 immediately. After release with `enable`=1 → `venster` high in the first cycle.
2. `slagen_in`=4 from time 0 → window 1 has 4 pulses starting at offsets 1, 251, 501, 751, each 10 cycles high, and `actief_slagen`=4.
3. `slagen_in`=0 → `venster` every 1000 cycles, `pulse` constantly 0, and `busy` high for exactly 1 cycle after each strobe.
4. `slagen_in`=255 → window 1 has 255 pulses with `I`=3, `Wp`=1. A counter model fed `pulse`/`venster` reads 255.
5. `slagen_in`=4, changed to 2 at offset 500 of window 1 → window 2 has 4 pulses and window 3 has 2.
6. With `HARTSLAG_JITTER_EN` defined and `slagen_in`=8 → 8 pulses per window, every gap in [117, 125], and the gap sequence repeats identically after reset.
